if_byte_fetcher: RTL and testbench

- Instruction-fetch requester on the shared byte-wide RAM port, on the IF side of the memory arbiter.
- Issues four sequential byte reads per instruction and raises its stop request while it needs the port.
- Tolerates preemption by MEM-stage accesses, assembles a little-endian 32-bit instruction and hands it to ID through a valid/ready register.
- Handles branch redirects, including discarding a byte that is already in flight.

---
 rtl/if_byte_fetcher_pkg.sv | 23 ++
 rtl/if_byte_fetcher_if.sv | 27 ++
 rtl/if_byte_fetcher_byte_assembler.sv | 46 ++++
 rtl/if_byte_fetcher.sv | 114 +++++++++++
 tb/tb_if_byte_fetcher.sv | 179 +++++++++++++++++
 5 files changed

// File: rtl/if_byte_fetcher_pkg.sv
// Shared definitions for the instruction-fetch byte requester:
// polarity constants, bus widths and fetch FSM encodings.
package if_byte_fetcher_pkg;

  localparam logic RstEnable    = 1'b1;
  localparam logic Stop         = 1'b1;
  localparam logic WriteDisable = 1'b0;

  localparam int InstAddrBus = 32;
  localparam int DataBus     = 32;

  localparam logic [DataBus-1:0] ZeroWord = '0;
  localparam logic [7:0]         Zero8    = '0;

  // Bytes per instruction word.
  localparam logic [2:0] BytesPerInst = 3'd4;

  typedef enum logic [0:0] {
    FETCH_S = 1'b0,
    VALID_S = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/if_byte_fetcher_if.sv
// Fetcher bus bundle: RAM/arbiter side, EX redirect and ID valid/ready handoff.
interface if_byte_fetcher_if #(
  parameter int ADDR_W = 32
);

  logic              grant_i;
  logic [7:0]        mem_din_i;
  logic              jump_i;
  logic [ADDR_W-1:0] jump_pc_i;
  logic              out_ready_i;
  logic              ctrl_req_o;
  logic [ADDR_W-1:0] mem_a_o;
  logic              inst_valid_o;
  logic [31:0]       inst_o;
  logic [ADDR_W-1:0] pc_o;

  modport master (
    input  grant_i, mem_din_i, jump_i, jump_pc_i, out_ready_i,
    output ctrl_req_o, mem_a_o, inst_valid_o, inst_o, pc_o
  );

  modport slave (
    output grant_i, mem_din_i, jump_i, jump_pc_i, out_ready_i,
    input  ctrl_req_o, mem_a_o, inst_valid_o, inst_o, pc_o
  );

endinterface

// File: rtl/if_byte_fetcher_byte_assembler.sv
// Collects four returning RAM bytes into a little-endian word; word/full
// already include the byte being written this cycle so completion needs no extra cycle.
module if_byte_fetcher_byte_assembler
  import if_byte_fetcher_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              clr,
  input  logic              wr,
  input  logic [7:0]        din,
  output logic [31:0]       word,
  output logic              full
);

  logic [7:0] bytes_q [4];
  logic [1:0] recv_cnt;

  assign full = wr && (recv_cnt == 2'd3);

  always_comb begin
    word = ZeroWord;
    for (int k = 0; k < 4; k++) begin
      if (wr && (recv_cnt == 2'(k)))
        word[8*k +: 8] = din;
      else
        word[8*k +: 8] = bytes_q[k];
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      recv_cnt <= 2'd0;
      for (int k = 0; k < 4; k++) bytes_q[k] <= Zero8;
    end else if (en) begin
      if (clr) begin
        recv_cnt <= 2'd0;
      end else if (wr) begin
        bytes_q[recv_cnt] <= din;
        // 2-bit counter wraps to 0 on the completing capture
        recv_cnt <= recv_cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/if_byte_fetcher.sv
// IF-side byte fetcher: issues four byte reads per instruction through the
// shared RAM port, survives MEM preemption and redirects, hands words to ID.
//
//   state   | meaning
//   FETCH_S | issuing and/or receiving instruction bytes
//   VALID_S | complete instruction held for ID
module if_byte_fetcher
  import if_byte_fetcher_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = InstAddrBus
) (
  input  logic clk,
  input  logic rst,
  input  logic rdy,
  if_byte_fetcher_if.master bus
);

  fetch_state_e      state, state_n;
  logic [ADDR_W-1:0] pc, pc_n;
  logic [2:0]        issue_cnt, issue_n;
  logic              pending, pending_n;
  logic              inst_valid, valid_n;
  logic [31:0]       inst_q, inst_n;
  logic [ADDR_W-1:0] pc_q, pcq_n;

  logic              asm_clr, asm_wr, asm_full;
  logic [31:0]       asm_word;

  if_byte_fetcher_byte_assembler u_asm (
    .clk  (clk),
    .rst  (rst),
    .en   (rdy),
    .clr  (asm_clr),
    .wr   (asm_wr),
    .din  (bus.mem_din_i),
    .word (asm_word),
    .full (asm_full)
  );

  assign bus.ctrl_req_o   = (state == FETCH_S) && (issue_cnt < BytesPerInst);
  assign bus.mem_a_o      = (state == FETCH_S) ? pc + ADDR_W'(issue_cnt) : '0;
  assign bus.inst_valid_o = inst_valid;
  assign bus.inst_o       = inst_q;
  assign bus.pc_o         = pc_q;

  always_comb begin
    state_n   = state;
    pc_n      = pc;
    issue_n   = issue_cnt;
    pending_n = 1'b0;
    valid_n   = inst_valid;
    inst_n    = inst_q;
    pcq_n     = pc_q;
    asm_clr   = 1'b0;
    asm_wr    = WriteDisable;
    if (bus.jump_i) begin
      // Dropping pending discards the byte already in flight.
      pc_n    = bus.jump_pc_i;
      issue_n = 3'd0;
      asm_clr = 1'b1;
      valid_n = 1'b0;
      state_n = FETCH_S;
    end else begin
      unique case (state)
        FETCH_S: begin
          if (bus.ctrl_req_o && bus.grant_i) begin
            issue_n   = issue_cnt + 3'd1;
            pending_n = 1'b1;
          end
          if (pending) begin
            asm_wr = 1'b1;
            if (asm_full) begin
              state_n = VALID_S;
              valid_n = 1'b1;
              inst_n  = asm_word;
              pcq_n   = pc;
              issue_n = 3'd0;
            end
          end
        end
        VALID_S: begin
          if (bus.out_ready_i) begin
            valid_n = 1'b0;
            pc_n    = pc + ADDR_W'(BytesPerInst);
            state_n = FETCH_S;
          end
        end
        default: state_n = FETCH_S;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst == RstEnable) begin
      state      <= FETCH_S;
      pc         <= RESET_PC[ADDR_W-1:0];
      issue_cnt  <= 3'd0;
      pending    <= 1'b0;
      inst_valid <= 1'b0;
      inst_q     <= ZeroWord;
      pc_q       <= '0;
    end else if (rdy) begin
      state      <= state_n;
      pc         <= pc_n;
      issue_cnt  <= issue_n;
      pending    <= pending_n;
      inst_valid <= valid_n;
      inst_q     <= inst_n;
      pc_q       <= pcq_n;
    end
  end

endmodule

// File: tb/tb_if_byte_fetcher.sv
// Directed bench for if_byte_fetcher: byte-RAM model with 1-cycle latency,
// arbiter grant = request && !preempt && rdy, hand-computed expectations.
module tb_if_byte_fetcher;

  logic clk = 1'b0;
  logic rst;
  logic rdy;
  logic preempt;
  logic [7:0] ram [1024];
  int errors = 0;
  int checks = 0;
  int n;

  always #5 clk = ~clk;

  if_byte_fetcher_if #(.ADDR_W(32)) bus ();

  if_byte_fetcher #(.RESET_PC(32'h0000_0000), .ADDR_W(32)) dut (
    .clk (clk),
    .rst (rst),
    .rdy (rdy),
    .bus (bus)
  );

  assign bus.grant_i = bus.ctrl_req_o && !preempt && rdy;

  always @(posedge clk)
    if (bus.grant_i) bus.mem_din_i <= ram[bus.mem_a_o[9:0]];

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_valid(input int budget, output int cnt);
    cnt = 0;
    while (!bus.inst_valid_o && cnt < budget) begin
      step();
      cnt++;
    end
    if (!bus.inst_valid_o) chk("valid_timeout", {31'd0, bus.inst_valid_o}, 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) ram[i] = 8'hEE;
    ram[0] = 8'h13; ram[1] = 8'h05; ram[2] = 8'hA0; ram[3] = 8'h00;
    ram[4] = 8'h11; ram[5] = 8'h22; ram[6] = 8'h33; ram[7] = 8'h44;
    ram[10] = 8'h5A;
    ram[32'h100] = 8'hEF; ram[32'h101] = 8'hBE; ram[32'h102] = 8'hAD; ram[32'h103] = 8'hDE;
    ram[32'h200] = 8'h01; ram[32'h201] = 8'h02; ram[32'h202] = 8'h03; ram[32'h203] = 8'h04;
    ram[10'h3FE] = 8'hAA; ram[10'h3FF] = 8'hBB;

    rst = 1'b1; rdy = 1'b1; preempt = 1'b0;
    bus.jump_i = 1'b0; bus.jump_pc_i = '0; bus.out_ready_i = 1'b0;
    bus.mem_din_i = 8'h00;
    step(); step();
    chk("rst_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("rst_inst", bus.inst_o, 32'd0);
    chk("rst_pc", bus.pc_o, 32'd0);
    chk("rst_req", {31'd0, bus.ctrl_req_o}, 32'd1);
    chk("rst_addr", bus.mem_a_o, 32'd0);
    rst = 1'b0;

    // Basic fetch, grant continuously high
    for (int i = 0; i < 4; i++) begin
      chk("basic_addr", bus.mem_a_o, 32'(i));
      step();
    end
    chk("basic_req_off", {31'd0, bus.ctrl_req_o}, 32'd0);
    chk("basic_not_yet", {31'd0, bus.inst_valid_o}, 32'd0);
    step();
    chk("basic_valid", {31'd0, bus.inst_valid_o}, 32'd1);
    chk("basic_inst", bus.inst_o, 32'h00A0_0513);
    chk("basic_pc", bus.pc_o, 32'd0);

    // Hold in VALID
    for (int i = 0; i < 3; i++) begin
      step();
      chk("hold_valid", {31'd0, bus.inst_valid_o}, 32'd1);
      chk("hold_req", {31'd0, bus.ctrl_req_o}, 32'd0);
      chk("hold_inst", bus.inst_o, 32'h00A0_0513);
    end
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    chk("accept_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("accept_addr", bus.mem_a_o, 32'd4);

    // Preemption after byte 1 issues
    step(); step();
    chk("pre_addr", bus.mem_a_o, 32'd6);
    preempt = 1'b1;
    for (int i = 0; i < 3; i++) begin
      chk("pre_hold_addr", bus.mem_a_o, 32'd6);
      chk("pre_req", {31'd0, bus.ctrl_req_o}, 32'd1);
      step();
    end
    preempt = 1'b0;
    chk("pre_resume_addr", bus.mem_a_o, 32'd6);
    wait_valid(20, n);
    chk("pre_latency", 32'(n), 32'd3);
    chk("pre_inst", bus.inst_o, 32'h4433_2211);
    chk("pre_pc", bus.pc_o, 32'd4);

    // Jump while byte 2 of the word at 8 is granted
    bus.out_ready_i = 1'b1;
    step();
    bus.out_ready_i = 1'b0;
    chk("j_start_addr", bus.mem_a_o, 32'd8);
    step(); step();
    chk("j_b2_addr", bus.mem_a_o, 32'd10);
    bus.jump_i = 1'b1; bus.jump_pc_i = 32'h100;
    step();
    bus.jump_i = 1'b0;
    chk("j_target_addr", bus.mem_a_o, 32'h100);
    wait_valid(20, n);
    chk("j_latency", 32'(n), 32'd5);
    chk("j_inst", bus.inst_o, 32'hDEAD_BEEF);
    chk("j_pc", bus.pc_o, 32'h100);

    // Jump and accept together in VALID
    bus.jump_i = 1'b1; bus.jump_pc_i = 32'h200; bus.out_ready_i = 1'b1;
    step();
    bus.jump_i = 1'b0; bus.out_ready_i = 1'b0;
    chk("ja_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("ja_addr", bus.mem_a_o, 32'h200);

    // rdy low mid-fetch
    step(); step();
    chk("rdy_addr", bus.mem_a_o, 32'h202);
    rdy = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      chk("rdy_freeze_addr", bus.mem_a_o, 32'h202);
      chk("rdy_freeze_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    end
    rdy = 1'b1;
    wait_valid(20, n);
    chk("rdy_latency", 32'(n), 32'd3);
    chk("rdy_inst", bus.inst_o, 32'h0403_0201);
    chk("rdy_pc", bus.pc_o, 32'h200);

    // Misaligned target wrapping past the top of the address space
    bus.jump_i = 1'b1; bus.jump_pc_i = 32'hFFFF_FFFE;
    step();
    bus.jump_i = 1'b0;
    chk("wrap_a0", bus.mem_a_o, 32'hFFFF_FFFE);
    step();
    chk("wrap_a1", bus.mem_a_o, 32'hFFFF_FFFF);
    step();
    chk("wrap_a2", bus.mem_a_o, 32'h0000_0000);
    step();
    chk("wrap_a3", bus.mem_a_o, 32'h0000_0001);
    wait_valid(20, n);
    chk("wrap_latency", 32'(n), 32'd2);
    chk("wrap_inst", bus.inst_o, 32'h0513_BBAA);
    chk("wrap_pc", bus.pc_o, 32'hFFFF_FFFE);

    // Reset while in VALID
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_valid", {31'd0, bus.inst_valid_o}, 32'd0);
    chk("rst2_addr", bus.mem_a_o, 32'd0);
    chk("rst2_req", {31'd0, bus.ctrl_req_o}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
